// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Multi-channel periodic / one-shot tick generator with
//                shadowed runtime divisor and mode updates. Optional square
//                wave outputs are enabled with the TICK_GEN_SQUARE_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = 24000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              int_osc,
    input  logic              nreset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] sq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] pending_w;

    // Out-of-range channel indices match no channel, so they read ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending_w[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] sh_div_q, sh_div_d;
        logic             mode_q, mode_d;
        logic             sh_mode_q, sh_mode_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] last_cnt;
        logic             wrap;
        logic             accept;

        // A divisor of 0 behaves like 1: the counter compares against 0.
        assign last_cnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);
        assign wrap     = (cnt_q == last_cnt);
        assign accept   = cfg_valid && !pend_q && (cfg_ch == CH_W'(g));

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            div_d     = div_q;
            mode_d    = mode_q;
            sh_div_d  = sh_div_q;
            sh_mode_d = sh_mode_q;
            pend_d    = pend_q;
            tick_d    = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (ch_en[g]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ch_en[g]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (mode_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_d = '0;
                    if (!ch_en[g]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // A running channel only swaps at a genuine wrap; a disable defers it one edge.
            if (pend_q && ((state_q != ST_RUN) || (ch_en[g] && wrap))) begin
                div_d  = sh_div_q;
                mode_d = sh_mode_q;
                pend_d = 1'b0;
            end

            if (accept) begin
                sh_div_d  = cfg_div;
                sh_mode_d = cfg_mode;
                pend_d    = 1'b1;
            end
        end

        always_ff @(posedge int_osc or negedge nreset) begin
            if (!nreset) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                div_q     <= DIV_RST;
                mode_q    <= 1'b0;
                sh_div_q  <= '0;
                sh_mode_q <= 1'b0;
                pend_q    <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                mode_q    <= mode_d;
                sh_div_q  <= sh_div_d;
                sh_mode_q <= sh_mode_d;
                pend_q    <= pend_d;
                tick_q    <= tick_d;
            end
        end

        assign tick[g]      = tick_q;
        assign busy[g]      = (state_q == ST_RUN);
        assign pending_w[g] = pend_q;

`ifdef TICK_GEN_SQUARE_EN
        logic sq_q, sq_d;

        always_comb begin
            sq_d = sq_q;
            if (state_d == ST_IDLE) begin
                sq_d = 1'b0;
            end else if (tick_d) begin
                sq_d = ~sq_q;
            end
        end

        always_ff @(posedge int_osc or negedge nreset) begin
            if (!nreset) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sq_d;
            end
        end

        assign sq[g] = sq_q;
`else
        assign sq[g] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tick_gen
//  Description : Directed, table-driven self-checking bench for tick_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 25;
    localparam int CH_W   = 1;

    logic              int_osc = 1'b0;
    logic              nreset;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] sq;

    tick_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(24000)
    ) dut (
        .int_osc  (int_osc),
        .nreset   (nreset),
        .ch_en    (ch_en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .tick     (tick),
        .busy     (busy),
        .sq       (sq)
    );

    always #5 int_osc = ~int_osc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]       en;
        logic             valid;
        logic             ch;
        logic [CNT_W-1:0] div;
        logic             mode;
        int               reps;
        logic [1:0]       exp_tick;
        logic [1:0]       exp_busy;
        logic             exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [1:0] en, input logic valid, input logic ch,
                               input int div, input logic mode, input int reps,
                               input logic [1:0] t, input logic [1:0] b, input logic r);
        vec_t x;
        x.en = en; x.valid = valid; x.ch = ch; x.div = CNT_W'(div); x.mode = mode;
        x.reps = reps; x.exp_tick = t; x.exp_busy = b; x.exp_ready = r;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge int_osc);
        @(negedge int_osc);
    endtask

    // Counts edges until tick[0] is seen high; gives up after a bounded budget.
    task automatic wait_tick0(output int n, output bit saw1);
        n = 0;
        saw1 = 1'b0;
        do begin
            step();
            n++;
            if (tick[1]) saw1 = 1'b1;
        end while (!tick[0] && n < 30000);
    endtask

    task automatic cfg_write(input logic ch, input int div, input logic mode);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = CNT_W'(div); cfg_mode = mode;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        int  n;
        bit  saw1;

        nreset = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        repeat (3) @(negedge int_osc);
        check("reset tick", tick, 0);
        check("reset busy", busy, 0);
        check("reset sq", sq, 0);
        check("reset ready", cfg_ready, 1);
        nreset = 1'b1;
        step();

        // Default divisor on channel 0
        ch_en = 2'b01;
        step();
        check("dflt busy edge0", busy, 2'b01);
        check("dflt tick edge0", tick, 2'b00);
        wait_tick0(n, saw1);
        check("dflt first period", n, 24000);
        wait_tick0(n, saw1);
        check("dflt second period", n, 24000);
        check("dflt tick1 quiet", saw1, 0);
        ch_en = 2'b00;
        step();
        check("dflt disable busy", busy, 2'b00);

        // Directed vectors: en, valid, ch, div, mode, reps, tick, busy, ready
        vecs.push_back(v(2'b00, 1, 0, 10, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 2, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 1, 0,  5, 0, 1, 2'b00, 2'b01, 0));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 6, 2'b00, 2'b01, 0));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 4, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 4, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        // one-shot on ch1
        vecs.push_back(v(2'b00, 1, 1,  3, 1, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 1,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 1, 2'b00, 2'b10, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 2, 2'b00, 2'b10, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 1, 2'b10, 2'b00, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 5, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b00, 0, 1,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 1, 2'b00, 2'b10, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 2, 2'b00, 2'b10, 1));
        vecs.push_back(v(2'b10, 0, 1,  0, 0, 1, 2'b10, 2'b00, 1));
        vecs.push_back(v(2'b00, 0, 1,  0, 0, 1, 2'b00, 2'b00, 1));
        // div = 0 then div = 1, dropping enable on a wrap cycle
        vecs.push_back(v(2'b00, 1, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 3, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b00, 1, 0,  1, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 3, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        // enable falls while a write is pending
        vecs.push_back(v(2'b00, 1, 0,  4, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 1, 0,  2, 0, 1, 2'b00, 2'b01, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b00, 2'b01, 1));
        // write on the wrap edge goes to the shadow; a held second write stalls
        vecs.push_back(v(2'b01, 1, 0,  3, 0, 1, 2'b01, 2'b01, 0));
        vecs.push_back(v(2'b01, 1, 0,  7, 0, 1, 2'b00, 2'b01, 0));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 2, 2'b00, 2'b01, 1));
        vecs.push_back(v(2'b01, 0, 0,  0, 0, 1, 2'b01, 2'b01, 1));
        vecs.push_back(v(2'b00, 0, 0,  0, 0, 1, 2'b00, 2'b00, 1));

        foreach (vecs[i]) begin
            ch_en     = vecs[i].en;
            cfg_valid = vecs[i].valid;
            cfg_ch    = vecs[i].ch;
            cfg_div   = vecs[i].div;
            cfg_mode  = vecs[i].mode;
            for (int r = 0; r < vecs[i].reps; r++) begin
                step();
                check($sformatf("vec%0d.%0d tick", i, r), tick, vecs[i].exp_tick);
                check($sformatf("vec%0d.%0d busy", i, r), busy, vecs[i].exp_busy);
                check($sformatf("vec%0d.%0d ready", i, r), cfg_ready, vecs[i].exp_ready);
`ifndef TICK_GEN_SQUARE_EN
                check($sformatf("vec%0d.%0d sq", i, r), sq, 2'b00);
`endif
            end
        end
        cfg_valid = 1'b0;

        // Asynchronous reset with a pending write in flight
        cfg_write(1'b1, 1, 1'b0);
        cfg_write(1'b0, 6, 1'b0);
        ch_en = 2'b11;
        step();
        step();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = CNT_W'(2); cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        check("pre-reset tick1", tick[1], 1);
        check("pre-reset busy", busy, 2'b11);
        check("pre-reset ready", cfg_ready, 0);
        #2 nreset = 1'b0;
        #1;
        check("async reset tick", tick, 0);
        check("async reset busy", busy, 0);
        check("async reset sq", sq, 0);
        check("async reset ready", cfg_ready, 1);
        @(negedge int_osc);
        nreset = 1'b1;
        step();
        check("post-reset busy", busy, 2'b11);
        wait_tick0(n, saw1);
        check("post-reset period", n, 24000);
        ch_en = 2'b00;
        step();

`ifdef TICK_GEN_SQUARE_EN
        cfg_write(1'b0, 4, 1'b0);
        ch_en = 2'b01;
        step();
        check("sq edge0", sq[0], 0);
        for (int k = 1; k < 20; k++) begin
            step();
            check($sformatf("sq edge%0d", k), sq[0], ((k / 4) % 2) == 1);
        end
        ch_en = 2'b00;
        step();
        check("sq idle", sq[0], 0);
`else
        check("sq tied", sq, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
